// File: rtl/pc_sequencer.sv
// Program counter sequencer: run handshake, writable branch-target LUT,
// return-address stack for call/return, and stall support.
module pc_sequencer #(
    parameter int D          = 12,
    parameter int LW         = 5,
    parameter int RAS_DEPTH  = 4,
    parameter int START_ADDR = 0,
    parameter int DONE_ADDR  = 128
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          stall,
    input  logic          reljump_en,
    input  logic          absjump_en,
    input  logic          call_en,
    input  logic          ret_en,
    input  logic [LW-1:0] lut_idx,
    input  logic          lut_wr_en,
    input  logic [LW-1:0] lut_wr_idx,
    input  logic [D-1:0]  lut_wr_data,
    output logic [D-1:0]  prog_ctr,
    output logic          busy,
    output logic          done,
    output logic          ras_overflow,
    output logic          ras_underflow
);

    localparam int              LUT_SIZE = 1 << LW;
    localparam int              PW       = $clog2(RAS_DEPTH + 1);
    localparam logic [D-1:0]    START_PC = D'(START_ADDR);
    localparam logic [D-1:0]    DONE_PC  = D'(DONE_ADDR);
    localparam logic [PW-1:0]   RAS_FULL = PW'(RAS_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t        state_reg, state_next;
    logic [D-1:0]  pc_reg, pc_next;
    logic [PW-1:0] ptr_reg, ptr_next;
    logic          ovf_reg, ovf_next;
    logic          unf_reg, unf_next;
    logic          busy_reg, done_reg;
    logic          push_en;
    logic [D-1:0]  pc_inc;
    logic [D-1:0]  lut_rd;
    logic [D-1:0]  pop_val;

    logic [D-1:0]  lut_mem_reg [LUT_SIZE];
    logic [D-1:0]  ras_mem_reg [RAS_DEPTH];

    // LUT is reset-cleared, so it lives in flops; a write lands after the
    // edge, so a same-cycle read of that index still sees the old entry.
    genvar gi;
    generate
        for (gi = 0; gi < LUT_SIZE; gi++) begin : g_lut
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    lut_mem_reg[gi] <= '0;
                else if (lut_wr_en && lut_wr_idx == LW'(gi))
                    lut_mem_reg[gi] <= lut_wr_data;
            end
        end

        for (gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    ras_mem_reg[gi] <= '0;
                else if (push_en && ptr_reg == PW'(gi))
                    ras_mem_reg[gi] <= pc_inc;
            end
        end
    endgenerate

    assign lut_rd = lut_mem_reg[lut_idx];
    assign pc_inc = pc_reg + D'(1);

    always_comb begin
        pop_val = '0;
        for (int i = 0; i < RAS_DEPTH; i++) begin
            if (ptr_reg == PW'(i + 1))
                pop_val = ras_mem_reg[i];
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ptr_next   = ptr_reg;
        ovf_next   = ovf_reg;
        unf_next   = unf_reg;
        push_en    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                pc_next = START_PC;
                if (req)
                    state_next = ST_RUN;
            end
            ST_RUN: begin
                // Reaching the terminal address wins over stall and strobes.
                if (pc_reg == DONE_PC) begin
                    state_next = ST_DONE;
                end else if (!stall) begin
                    if (ret_en) begin
                        if (ptr_reg != '0) begin
                            pc_next  = pop_val;
                            ptr_next = ptr_reg - PW'(1);
                        end else begin
                            unf_next = 1'b1;
                            pc_next  = pc_inc;
                        end
                    end else if (call_en) begin
                        if (ptr_reg != RAS_FULL) begin
                            push_en  = 1'b1;
                            ptr_next = ptr_reg + PW'(1);
                        end else begin
                            ovf_next = 1'b1;
                        end
                        pc_next = lut_rd;
                    end else if (absjump_en) begin
                        pc_next = lut_rd;
                    end else if (reljump_en) begin
                        pc_next = pc_reg + lut_rd;
                    end else begin
                        pc_next = pc_inc;
                    end
                end
            end
            ST_DONE: begin
                if (req) begin
                    state_next = ST_RUN;
                    pc_next    = START_PC;
                    ptr_next   = '0;
                    ovf_next   = 1'b0;
                    unf_next   = 1'b0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                pc_next    = START_PC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            pc_reg    <= START_PC;
            ptr_reg   <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ptr_reg   <= ptr_next;
            ovf_reg   <= ovf_next;
            unf_reg   <= unf_next;
            busy_reg  <= (state_next == ST_RUN);
            done_reg  <= (state_next == ST_DONE);
        end
    end

    assign prog_ctr      = pc_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;
    assign ras_overflow  = ovf_reg;
    assign ras_underflow = unf_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, free run to DONE, then a vector
// table covering jumps, calls, RAS limits, stall, priority and restart.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, stall, reljump_en, absjump_en, call_en, ret_en;
    logic [4:0]  lut_idx;
    logic        lut_wr_en;
    logic [4:0]  lut_wr_idx;
    logic [11:0] lut_wr_data;
    logic [11:0] prog_ctr;
    logic        busy, done, ras_overflow, ras_underflow;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(
        .D(12), .LW(5), .RAS_DEPTH(4), .START_ADDR(0), .DONE_ADDR(128)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .stall(stall),
        .reljump_en(reljump_en), .absjump_en(absjump_en),
        .call_en(call_en), .ret_en(ret_en), .lut_idx(lut_idx),
        .lut_wr_en(lut_wr_en), .lut_wr_idx(lut_wr_idx),
        .lut_wr_data(lut_wr_data), .prog_ctr(prog_ctr), .busy(busy),
        .done(done), .ras_overflow(ras_overflow),
        .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rq, st, rt, cl, ab, rl;
        logic [4:0]  idx;
        logic        we;
        logic [4:0]  widx;
        logic [11:0] wdata;
        logic [11:0] pc;
        logic        b, dn, ov, un;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rq, st, rt, cl, ab, rl,
                                input logic [4:0] idx, input logic [11:0] pc,
                                input logic b, dn, ov, un);
        vec_t v;
        v.rq = rq; v.st = st; v.rt = rt; v.cl = cl; v.ab = ab; v.rl = rl;
        v.idx = idx; v.we = 1'b0; v.widx = '0; v.wdata = '0;
        v.pc = pc; v.b = b; v.dn = dn; v.ov = ov; v.un = un;
        return v;
    endfunction

    task automatic check(input string name, input logic [11:0] pc,
                         input logic b, dn, ov, un);
        checks++;
        if ({prog_ctr, busy, done, ras_overflow, ras_underflow} !== {pc, b, dn, ov, un}) begin
            errors++;
            $display("FAIL %s: got pc=%0d busy=%b done=%b ovf=%b unf=%b, expected pc=%0d busy=%b done=%b ovf=%b unf=%b",
                     name, prog_ctr, busy, done, ras_overflow, ras_underflow,
                     pc, b, dn, ov, un);
        end else begin
            $display("ok   %s: pc=%0d busy=%b done=%b ovf=%b unf=%b",
                     name, prog_ctr, busy, done, ras_overflow, ras_underflow);
        end
    endtask

    task automatic clear_inputs();
        req = 0; stall = 0; reljump_en = 0; absjump_en = 0; call_en = 0;
        ret_en = 0; lut_idx = '0; lut_wr_en = 0; lut_wr_idx = '0; lut_wr_data = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [4:0]  init_idx  [11];
    logic [11:0] init_data [11];

    initial begin
        init_idx  = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11};
        init_data = '{12'd40, 12'hFFF, 12'hFFE, 12'd10, 12'd60, 12'd50, 12'd5,
                      12'd20, 12'd49, 12'd127, 12'd30};

        //          rq st rt cl ab rl idx  pc       b  dn ov un
        vecs.push_back(mk(1,0,0,0,0,0, 0, 12'd0,    1,0,0,0)); // 0 restart from DONE
        vecs.push_back(mk(0,0,0,0,1,0, 4, 12'd10,   1,0,0,0)); // 1 abs
        vecs.push_back(mk(0,0,0,0,0,1, 3, 12'd8,    1,0,0,0)); // 2 rel -2
        vecs.push_back(mk(0,0,0,0,1,0, 2, 12'hFFF,  1,0,0,0)); // 3
        vecs.push_back(mk(0,0,0,0,0,0, 0, 12'd0,    1,0,0,0)); // 4 wrap
        vecs.push_back(mk(0,0,0,0,1,0, 7, 12'd5,    1,0,0,0)); // 5
        vecs.push_back(mk(0,0,0,1,0,0, 1, 12'd40,   1,0,0,0)); // 6 call push 6
        vecs.push_back(mk(0,0,0,0,0,0, 0, 12'd41,   1,0,0,0)); // 7
        vecs.push_back(mk(0,0,1,0,0,0, 0, 12'd6,    1,0,0,0)); // 8 ret
        vecs.push_back(mk(1,0,0,0,0,0, 0, 12'd7,    1,0,0,0)); // 9 req ignored in RUN
        vecs.push_back(mk(0,0,0,1,0,0, 1, 12'd40,   1,0,0,0)); // 10 push 8
        vecs.push_back(mk(0,0,0,1,0,0, 6, 12'd50,   1,0,0,0)); // 11 push 41
        vecs.push_back(mk(0,0,0,1,0,0, 4, 12'd10,   1,0,0,0)); // 12 push 51
        vecs.push_back(mk(0,0,0,1,0,0, 7, 12'd5,    1,0,0,0)); // 13 push 11
        vecs.push_back(mk(0,0,0,1,0,0, 1, 12'd40,   1,0,1,0)); // 14 overflow
        vecs.push_back(mk(0,0,1,0,0,0, 0, 12'd11,   1,0,1,0)); // 15
        vecs.push_back(mk(0,0,1,0,0,0, 0, 12'd51,   1,0,1,0)); // 16
        vecs.push_back(mk(0,0,1,0,0,0, 0, 12'd41,   1,0,1,0)); // 17
        vecs.push_back(mk(0,0,1,0,0,0, 0, 12'd8,    1,0,1,0)); // 18
        vecs.push_back(mk(0,0,1,0,0,0, 0, 12'd9,    1,0,1,1)); // 19 underflow
        vecs.push_back(mk(0,0,0,1,0,0, 8, 12'd20,   1,0,1,1)); // 20 push 10
        vecs.push_back(mk(0,1,0,1,1,0, 1, 12'd20,   1,0,1,1)); // 21 stall
        vecs.push_back(mk(0,1,0,1,0,0, 1, 12'd20,   1,0,1,1)); // 22 stall
        vecs.push_back(mk(0,1,0,0,1,0, 1, 12'd20,   1,0,1,1)); // 23 stall
        vecs.push_back(mk(0,0,0,0,0,0, 0, 12'd21,   1,0,1,1)); // 24 release
        vecs.push_back(mk(0,0,1,0,0,0, 0, 12'd10,   1,0,1,1)); // 25 RAS untouched by stall
        vecs.push_back(mk(0,0,0,0,1,0, 9, 12'd49,   1,0,1,1)); // 26
        vecs.push_back(mk(0,0,0,1,0,0, 4, 12'd10,   1,0,1,1)); // 27 push 50
        vecs.push_back(mk(0,0,1,1,1,0, 1, 12'd50,   1,0,1,1)); // 28 ret wins
        vecs.push_back(mk(0,0,0,0,1,0, 5, 12'd60,   1,0,1,1)); // 29 old LUT value
        vecs.push_back(mk(0,0,0,0,1,0, 5, 12'd100,  1,0,1,1)); // 30 new LUT value
        vecs.push_back(mk(0,0,0,0,1,0,10, 12'd127,  1,0,1,1)); // 31
        vecs.push_back(mk(0,0,0,0,0,0, 0, 12'd128,  1,0,1,1)); // 32
        vecs.push_back(mk(0,1,0,1,0,0, 1, 12'd128,  0,1,1,1)); // 33 done despite stall
        vecs.push_back(mk(0,0,0,0,1,0, 1, 12'd128,  0,1,1,1)); // 34 strobes ignored
        vecs.push_back(mk(1,0,0,0,0,0, 0, 12'd0,    1,0,0,0)); // 35 restart clears flags
        vecs.push_back(mk(1,0,0,0,1,0,10, 12'd127,  1,0,0,0)); // 36
        vecs.push_back(mk(1,0,0,0,0,0, 0, 12'd128,  1,0,0,0)); // 37
        vecs.push_back(mk(1,0,0,0,0,0, 0, 12'd128,  0,1,0,0)); // 38
        vecs.push_back(mk(1,0,0,0,0,0, 0, 12'd0,    1,0,0,0)); // 39 held req restarts
        vecs.push_back(mk(0,0,0,0,1,0,11, 12'd30,   1,0,0,0)); // 40
        vecs[29].we = 1'b1; vecs[29].widx = 5'd5; vecs[29].wdata = 12'd100;

        clear_inputs();
        reset = 1'b0;
        #12;
        check("reset_state", 12'd0, 0, 0, 0, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            lut_wr_en = 1'b1; lut_wr_idx = init_idx[i]; lut_wr_data = init_data[i];
            step();
            check($sformatf("idle_lut_wr%0d", i), 12'd0, 0, 0, 0, 0);
        end
        clear_inputs();

        req = 1'b1;
        step();
        req = 1'b0;
        check("run_start", 12'd0, 1, 0, 0, 0);
        for (int k = 1; k <= 128; k++) begin
            step();
            check($sformatf("free_run_%0d", k), 12'(k), 1, 0, 0, 0);
        end
        step();
        check("free_run_done", 12'd128, 0, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            req = vecs[i].rq; stall = vecs[i].st; ret_en = vecs[i].rt;
            call_en = vecs[i].cl; absjump_en = vecs[i].ab; reljump_en = vecs[i].rl;
            lut_idx = vecs[i].idx; lut_wr_en = vecs[i].we;
            lut_wr_idx = vecs[i].widx; lut_wr_data = vecs[i].wdata;
            step();
            check($sformatf("vec%0d", i), vecs[i].pc, vecs[i].b, vecs[i].dn,
                  vecs[i].ov, vecs[i].un);
        end
        clear_inputs();

        // Asynchronous reset mid-cycle while at prog_ctr=30.
        #3;
        reset = 1'b0;
        #1;
        check("async_reset", 12'd0, 0, 0, 0, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        req = 1'b1;
        step();
        req = 1'b0;
        check("post_reset_run", 12'd0, 1, 0, 0, 0);
        absjump_en = 1'b1; lut_idx = 5'd1;
        step();
        clear_inputs();
        check("lut_cleared", 12'd0, 1, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised successor to the fixed 12-bit program counter and its hard-wired jump lookup table.
- Combines the program counter, a run-time-writable branch-target LUT, a return-address stack (RAS) for call/return, stall support and a req/done run handshake in one sequential block.
- Sits between the control decoder (jump/call/return strobes, LUT index) and the instruction ROM (prog_ctr).

Parameters:
D, 12, program counter width in bits
LW, 5, LUT index width; LUT holds 2**LW entries of D bits
RAS_DEPTH, 4, return-address stack entries (>=1)
START_ADDR, 0, prog_ctr value at reset and at each run start
DONE_ADDR, 128, prog_ctr value that terminates a run

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
req  in  1  start request, level-sampled in IDLE and DONE
stall  in  1  freeze prog_ctr, RAS and state for this cycle
reljump_en  in  1  relative jump: prog_ctr += signed LUT entry
absjump_en  in  1  absolute jump: prog_ctr = LUT entry
call_en  in  1  push prog_ctr+1, then prog_ctr = LUT entry
ret_en  in  1  prog_ctr = popped RAS entry
lut_idx  in  LW  LUT read index for jump/call
lut_wr_en  in  1  LUT write strobe
lut_wr_idx  in  LW  LUT write index
lut_wr_data  in  D  LUT write data
prog_ctr  out  D  current instruction address (registered)
busy  out  1  high in RUN
done  out  1  high in DONE
ras_overflow  out  1  sticky: call issued with RAS full
ras_underflow  out  1  sticky: return issued with RAS empty

Behaviour:
- Reset (async, reset=0): prog_ctr=START_ADDR, state=IDLE, busy=0, done=0, both sticky flags=0, RAS pointer=0, all LUT entries=0. All outputs are registered.
- State IDLE:
  - prog_ctr holds START_ADDR.
  - req=1 -> RUN next edge; prog_ctr stays START_ADDR, so the first fetch is START_ADDR.
- State RUN, busy=1, one update per cycle when stall=0. Priority is ret_en > call_en > absjump_en > reljump_en > increment; lower-priority strobes are ignored.
  - Increment: prog_ctr+1 mod 2**D.
  - Relative jump: prog_ctr + LUT[lut_idx]. The LUT entry is a D-bit two's-complement offset; the result wraps mod 2**D.
  - Absolute jump: prog_ctr = LUT[lut_idx].
  - Call:
    - RAS not full: push prog_ctr+1 (wrapped), then jump to LUT[lut_idx].
    - RAS full: set ras_overflow, skip the push, still jump.
  - Return:
    - RAS not empty: pop into prog_ctr.
    - RAS empty: set ras_underflow; prog_ctr increments.
- stall=1 in RUN: prog_ctr, RAS and flags are unchanged; all strobes in that cycle are discarded and not replayed.
- Done detection:
  - In RUN, if the registered prog_ctr == DONE_ADDR, the next edge enters DONE, regardless of stall or strobes.
  - prog_ctr holds DONE_ADDR, busy=0, done=1.
- State DONE:
  - Strobes are ignored.
  - req=1 -> RUN next edge. That edge clears the flags, clears the RAS and loads prog_ctr=START_ADDR; done falls the same edge.
  - A req held high continuously from the previous run restarts immediately.
- req in RUN is ignored.
- LUT writes are accepted in any state, including under stall. A same-cycle read of the written index returns the old value; the new value is visible next cycle.
- Reset mid-run aborts immediately to the reset values above. LUT contents are cleared.

Test Plan:
- Reset then req=1 for 1 cycle, no strobes, D=12 -> prog_ctr 0,0,1,2,…,128; done=1 the cycle after prog_ctr==128; busy falls the same edge.
- LUT[3]=12'hFFE (-2); in RUN at prog_ctr=10 assert reljump_en, lut_idx=3 -> prog_ctr=8. At prog_ctr=12'hFFF with increment -> prog_ctr=0 (wrap).
- LUT[1]=40; call at prog_ctr=5 -> prog_ctr=40; ret at 41 -> prog_ctr=6; both flags stay 0.
- RAS_DEPTH=4: five nested calls to LUT[1]=40 -> fifth still jumps to 40 and ras_overflow=1. Four rets return in LIFO order; a fifth ret sets ras_underflow and increments.
- At prog_ctr=20, stall=1 for 3 cycles with call_en and absjump_en pulsed -> prog_ctr stays 20 and the RAS is unchanged. After release prog_ctr=21.
- Same-cycle ret_en+call_en+absjump_en with RAS holding 50 -> prog_ctr=50. Reset asserted mid-run at prog_ctr=30 -> prog_ctr=0, IDLE, done=0 asynchronously.
